// File: rtl/sram_fifo_ctrl.sv
// FIFO controller driving a single-port RAM: push/pop valid/ready streams, one RAM access per cycle,
// 2-entry output buffer hiding read latency. Optional high-water-mark port under `SRAM_FIFO_HWM_EN.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 2) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic                  ram_read_en,
  output logic                  ram_write_en,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef SRAM_FIFO_HWM_EN
  ,
  output logic [CNT_WIDTH-1:0]  hwm
`endif
);

  localparam int RW = ADDR_WIDTH + 1;
  localparam logic [RW-1:0]         RAM_FULL  = RW'(DEPTH);
  localparam logic [RW-1:0]         RAM_EMPTY = RW'(0);
  localparam logic [RW-1:0]         RAM_ONE   = RW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [RW-1:0]         ram_cnt_r;
  logic                  inflight_r;
  logic                  last_gnt_r;
  logic [DATA_WIDTH-1:0] ob_mem_r [2];
  logic                  ob_rd_r;
  logic                  ob_wr_r;
  logic [1:0]            ob_cnt_r;

  logic rd_elig_s;
  logic rd_gnt_s;
  logic pop_s;

  // Single-port arbitration: reads win unless a write is waiting and the last grant was a read.
  always_comb begin
    rd_elig_s    = (ram_cnt_r != RAM_EMPTY) &&
                   (({1'b0, ob_cnt_r} + {2'b00, inflight_r}) < 3'd2);
    rd_gnt_s     = rd_elig_s && (!push_valid || (ram_cnt_r == RAM_FULL) || !last_gnt_r);
    push_ready   = (ram_cnt_r != RAM_FULL) && !rd_gnt_s && !clear;
    ram_write_en = push_valid && push_ready;
    ram_read_en  = rd_gnt_s && !clear;
    pop_valid    = (ob_cnt_r != 2'd0);
    pop_s        = pop_valid && pop_ready;
    pop_data     = ob_mem_r[ob_rd_r];
  end

  assign ram_addr_r  = rd_ptr_r;
  assign ram_addr_w  = wr_ptr_r;
  assign ram_data_in = push_data;
  assign count       = CNT_WIDTH'(ram_cnt_r) + CNT_WIDTH'(inflight_r) + CNT_WIDTH'(ob_cnt_r);

  // Pointers, RAM occupancy, in-flight read tracking and output-buffer bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      ram_cnt_r  <= '0;
      inflight_r <= 1'b0;
      last_gnt_r <= 1'b0;
      ob_rd_r    <= 1'b0;
      ob_wr_r    <= 1'b0;
      ob_cnt_r   <= 2'd0;
    end else if (clear) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      ram_cnt_r  <= '0;
      inflight_r <= 1'b0;
      last_gnt_r <= 1'b0;
      ob_rd_r    <= 1'b0;
      ob_wr_r    <= 1'b0;
      ob_cnt_r   <= 2'd0;
    end else begin
      inflight_r <= ram_read_en;
      if (ram_write_en) begin
        wr_ptr_r   <= wr_ptr_r + PTR_ONE;
        ram_cnt_r  <= ram_cnt_r + RAM_ONE;
        last_gnt_r <= 1'b0;
      end else if (ram_read_en) begin
        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
        ram_cnt_r  <= ram_cnt_r - RAM_ONE;
        last_gnt_r <= 1'b1;
      end else begin
        last_gnt_r <= last_gnt_r;
      end
      if (inflight_r) begin
        ob_wr_r <= ~ob_wr_r;
      end else begin
        ob_wr_r <= ob_wr_r;
      end
      if (pop_s) begin
        ob_rd_r <= ~ob_rd_r;
      end else begin
        ob_rd_r <= ob_rd_r;
      end
      case ({inflight_r, pop_s})
        2'b10:   ob_cnt_r <= ob_cnt_r + 2'd1;
        2'b01:   ob_cnt_r <= ob_cnt_r - 2'd1;
        default: ob_cnt_r <= ob_cnt_r;
      endcase
    end
  end

  // Output-buffer storage; a read landing during clear is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_mem_r[0] <= '0;
      ob_mem_r[1] <= '0;
    end else if (inflight_r && !clear) begin
      ob_mem_r[ob_wr_r] <= ram_data_out;
    end else begin
      ob_mem_r[0] <= ob_mem_r[0];
      ob_mem_r[1] <= ob_mem_r[1];
    end
  end

`ifdef SRAM_FIFO_HWM_EN
  logic [CNT_WIDTH-1:0] hwm_r;

  // Peak occupancy since the last reset or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_r <= '0;
    end else if (clear) begin
      hwm_r <= '0;
    end else if (count > hwm_r) begin
      hwm_r <= count;
    end else begin
      hwm_r <= hwm_r;
    end
  end

  assign hwm = hwm_r;
`endif

endmodule
